// File: rtl/sw_bounce_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sw_bounce_gen
// Description : Mechanical-switch bounce emulator. Converts a clean level
//               request into a switch-like output: the first contact is
//               made as soon as the synchronised request changes, the
//               output then chatters once per prescaler tick and finally
//               settles on the requested level.
//
// Parameters  : P            - prescaler width, one tick every 2^P clocks
//               BOUNCE_TICKS - ticks in the bounce window, including the
//                              final settling tick (must be >= 1)
//
// Ports       : clk      in  system clock
//               reset    in  asynchronous, active-high reset
//               level_in in  requested clean level (may be asynchronous)
//               sw_out   out emulated bouncy switch output (registered)
//               busy     out high while the output is bouncing
//               done     out one-cycle pulse on the settling edge
//
// Build macro : SW_BOUNCE_LFSR_EN - when defined, the chatter comes from
//               bit 0 of a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1,
//               seed 16'hACE1) advanced on every tick. When undefined,
//               the output simply toggles on each chatter tick.
//
// Revision    : 1.0 - initial release
// ============================================================================
module sw_bounce_gen #(
    parameter int P            = 19,
    parameter int BOUNCE_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic sw_out,
    output logic busy,
    output logic done
);

    // Bounce counter needs at least one bit even when BOUNCE_TICKS is 1.
    localparam int                 c_CNT_W     = (BOUNCE_TICKS > 1) ? $clog2(BOUNCE_TICKS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_TICK = c_CNT_W'(BOUNCE_TICKS - 1);

    // One-hot encoding; anything else is treated as illegal and recovers
    // to STABLE.
    localparam logic [1:0] c_ST_STABLE = 2'b01;
    localparam logic [1:0] c_ST_BOUNCE = 2'b10;

    logic               r_sync1;
    logic               r_sync2;
    logic [P-1:0]       r_q;
    logic               w_tick;
    logic               w_pattern;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_target;
    logic               w_target_nxt;
    logic [c_CNT_W-1:0] r_b;
    logic [c_CNT_W-1:0] w_b_nxt;
    logic               r_sw;
    logic               w_sw_nxt;
    logic               r_done;
    logic               w_done_nxt;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous level request
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= level_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Free-running prescaler; tick on the all-ones count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_q + P'(1);
        end
    end

    assign w_tick = &r_q;

    // ------------------------------------------------------------------
    // Chatter pattern source
    // ------------------------------------------------------------------
`ifdef SW_BOUNCE_LFSR_EN
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    // Taps for x^16+x^14+x^13+x^11+1 in a right-shifting Fibonacci LFSR:
    // bits 0, 2, 3 and 5 feed the new MSB.
    localparam logic [15:0] c_LFSR_TAPS = 16'h002D;

    logic [15:0] r_lfsr;

    // Advances on every tick regardless of state so the chatter seen by
    // successive requests differs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (w_tick) begin
            r_lfsr <= {^(r_lfsr & c_LFSR_TAPS), r_lfsr[15:1]};
        end
    end

    assign w_pattern = r_lfsr[0];
`else
    assign w_pattern = ~r_sw;
`endif

    // ------------------------------------------------------------------
    // FSM state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_STABLE;
            r_target <= 1'b0;
            r_b      <= '0;
            r_sw     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_b      <= w_b_nxt;
            r_sw     <= w_sw_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_b_nxt      = r_b;
        w_sw_nxt     = r_sw;
        w_done_nxt   = 1'b0;

        case (r_state)
            c_ST_STABLE: begin
                if (r_sync2 != r_target) begin
                    // First contact: output follows the request at once.
                    w_target_nxt = r_sync2;
                    w_sw_nxt     = r_sync2;
                    w_b_nxt      = '0;
                    w_state_nxt  = c_ST_BOUNCE;
                end
            end

            c_ST_BOUNCE: begin
                if (r_sync2 != r_target) begin
                    // A new request restarts the window; it wins over a
                    // coincident tick and never produces a done pulse.
                    w_target_nxt = r_sync2;
                    w_sw_nxt     = r_sync2;
                    w_b_nxt      = '0;
                end else if (w_tick) begin
                    if (r_b == c_LAST_TICK) begin
                        w_sw_nxt    = r_target;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = c_ST_STABLE;
                    end else begin
                        w_b_nxt  = r_b + c_CNT_W'(1);
                        w_sw_nxt = w_pattern;
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_STABLE;
            end
        endcase
    end

    assign sw_out = r_sw;
    assign done   = r_done;
    assign busy   = (r_state == c_ST_BOUNCE);

endmodule
`default_nettype wire

// File: tb/tb_sw_bounce_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sw_bounce_gen
// Description : Self-checking bench for sw_bounce_gen (P=2, BOUNCE_TICKS=4).
//               Each level request pushes its expected entry, chatter and
//               settle events into a scoreboard; a monitor pops them on the
//               matching clock edge and otherwise expects the outputs to
//               hold. Chatter comes from a request table (toggle build) or
//               from a golden LFSR model (SW_BOUNCE_LFSR_EN build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_bounce_gen;

    localparam int P   = 2;
    localparam int BT  = 4;
    localparam int PER = 1 << P;

    logic clk = 1'b0;
    logic reset;
    logic level_in;
    logic sw_out;
    logic busy;
    logic done;

    sw_bounce_gen #(
        .P            (P),
        .BOUNCE_TICKS (BT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .level_in (level_in),
        .sw_out   (sw_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Request record: level to drive plus expected sw_out at entry, at each
    // chatter tick, and at the settling tick (index BT).
    typedef struct {
        bit          lvl;
        logic [BT:0] exp;
    } vec_t;

    typedef struct {
        int edge_n;
        bit sw;
        bit bsy;
        bit dn;
    } ev_t;

    ev_t  sb[$];
    vec_t vec[4];
    int   ecnt;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    bit   cur_sw   = 1'b0;
    bit   cur_busy = 1'b0;
    int   t1;

    // Clock edges since reset release; ticks land on multiples of PER.
    always @(posedge clk or posedge reset) begin
        if (reset) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // LFSR bit 0 as seen on tick number t (t=1 is the first tick).
    function automatic bit lfsr_bit(input int t);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 1; i < t; i++) s = lfsr_step(s);
        return s[0];
    endfunction

    task automatic check(input string name, input bit e_sw, input bit e_busy, input bit e_done);
        n_checks++;
        if (sw_out !== e_sw || busy !== e_busy || done !== e_done) begin
            n_fail++;
            $display("FAIL %s at edge %0d: sw_out/busy/done = %b/%b/%b, expected %b/%b/%b",
                     name, ecnt, sw_out, busy, done, e_sw, e_busy, e_done);
        end
    endtask

    // Monitor: compare against the scoreboard on event edges, otherwise
    // the outputs must hold and done must stay low.
    always @(negedge clk) begin : monitor
        ev_t ev;
        if (mon_en && !reset) begin
            if (sb.size() > 0 && sb[0].edge_n == ecnt) begin
                ev = sb.pop_front();
                check(ev.dn ? "settle" : "event", ev.sw, ev.bsy, ev.dn);
                cur_sw   = ev.sw;
                cur_busy = ev.bsy;
            end else begin
                check("hold", cur_sw, cur_busy, 1'b0);
            end
        end
    end

    // Drive a request at the current negedge and queue what must follow.
    task automatic request(input vec_t v, output int first_tick);
        int e;
        int t;
        bit p;
        level_in = v.lvl;
        e = ecnt + 3;
        while (sb.size() > 0 && sb[sb.size()-1].edge_n >= e) sb.delete(sb.size() - 1);
        sb.push_back('{e, v.exp[0], 1'b1, 1'b0});
        t = (e / PER + 1) * PER;
        first_tick = t;
        for (int k = 1; k <= BT; k++) begin
            if (k < BT) begin
`ifdef SW_BOUNCE_LFSR_EN
                p = lfsr_bit(t / PER);
`else
                p = v.exp[k];
`endif
                sb.push_back('{t, p, 1'b1, 1'b0});
            end else begin
                sb.push_back('{t, v.exp[BT], 1'b0, 1'b1});
            end
            t += PER;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL %s timeout: %0d events pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_edge(input int target);
        int n;
        n = 0;
        while (ecnt != target && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (ecnt != target) begin
            n_fail++;
            $display("FAIL wait_edge timeout: edge %0d, expected %0d", ecnt, target);
        end
    endtask

    initial begin
        reset    = 1'b1;
        level_in = 1'b0;

        vec[0] = '{lvl: 1'b1, exp: 5'b10101};
        vec[1] = '{lvl: 1'b0, exp: 5'b01010};
        vec[2] = '{lvl: 1'b1, exp: 5'b10101};
        vec[3] = '{lvl: 1'b0, exp: 5'b01010};

        // Reset state
        repeat (3) begin
            @(negedge clk);
            check("reset", 1'b0, 1'b0, 1'b0);
        end
        reset  = 1'b0;
        mon_en = 1'b1;

        // Idle with level_in low: nothing may move for 100 cycles
        repeat (100) @(negedge clk);

        // Table-driven rising / falling requests
        for (int i = 0; i < 4; i++) begin
            request(vec[i], t1);
            wait_idle("table");
            repeat (5) @(negedge clk);
        end

        // Retrigger after two chatter ticks
        request(vec[0], t1);
        wait_edge(t1 + PER);
        request(vec[1], t1);
        wait_idle("retrigger");
        repeat (5) @(negedge clk);

        // Reset in the middle of a bounce with level_in held high
        request(vec[0], t1);
        wait_edge(t1);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("reset_async", 1'b0, 1'b0, 1'b0);
        sb.delete();
        cur_sw   = 1'b0;
        cur_busy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("reset_held", 1'b0, 1'b0, 1'b0);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        request(vec[0], t1);
        wait_idle("reset_reentry");
        repeat (5) @(negedge clk);

        // Final falling request
        request(vec[1], t1);
        wait_idle("final");
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sw_bounce_gen.md
# sw_bounce_gen

Mechanical-switch bounce emulator: the stimulus-side counterpart of the switch debouncers in this codebase. Takes a clean level request from a test controller or a board switch, and drives a switch-like output that makes its first contact immediately, then chatters for a programmable number of timer ticks before settling. Used for on-FPGA self-test of debouncer FSMs and for loopback demos on the board.

## Interface
- `P`, 19, prescaler width; one tick every 2^P clk cycles (~10.5 ms at 50 MHz).
- `BOUNCE_TICKS`, 3, ticks in the bounce window, including the final settling tick; legal range ≥1.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `level_in`  input  1  requested clean switch level; may be asynchronous to `clk`.
- `sw_out`  output  1  emulated bouncy switch output, registered.
- `busy`  output  1  high while in BOUNCE.
- `done`  output  1  single-cycle pulse when the output settles.

## Operation
- Reset is asynchronous, active-high; clock is `clk`.
- **Input sync:** `level_in` passes through a 2-flop synchronizer giving `lvl_s`.
- **Prescaler:** `q` is P bits, reset to 0, and increments every cycle with wrap. `tick` = (`q` == 2^P−1).
- **Registers:** `target` (1 bit); bounce counter `b`, $clog2(BOUNCE_TICKS) bits with a minimum of 1 bit; `sw_out`; state.
- **State STABLE** (reset state; `busy`=0):
  - `lvl_s` != `target` → `target`<=`lvl_s`, `sw_out`<=`lvl_s` (first contact), `b`<=0, go to BOUNCE.
- **State BOUNCE** (`busy`=1):
  - `lvl_s` != `target` takes priority over `tick` (retrigger): `target`<=`lvl_s`, `sw_out`<=`lvl_s`, `b`<=0, stay in BOUNCE. There is no `done` pulse.
  - Else on `tick` with `b` == BOUNCE_TICKS−1: `sw_out`<=`target`, `done`<=1 for one cycle, go to STABLE.
  - Else on `tick`: `b`<=`b`+1, `sw_out`<=pattern bit (see Configuration).
  - With no tick, all registers hold.
- **Boundary cases:**
  - BOUNCE_TICKS=1 → no chatter; the first tick after entry settles.
  - The window length is not tick-aligned: from entry to settle is 1..2^P cycles to the first tick, plus (BOUNCE_TICKS−1)·2^P cycles.
  - Illegal state encodings → STABLE.
- **Reset mid-bounce:** everything is cleared immediately, and `sw_out` goes to 0. If `lvl_s`=1 after the synchronizer refills, the block re-enters BOUNCE.

## Timing
- **Reset values:** `sw_out`=0, `busy`=0, `done`=0, `target`=0, `b`=0, `q`=0, synchronizer=0, LFSR=16'hACE1.
- **Input latency:** a `level_in` change reaches `sw_out` in 3 clk edges (2 synchronizer edges plus 1 FSM edge). `busy` rises on that same edge.
- **Output settling:** `done` and the final `sw_out` value are updated on the same edge; `busy` falls on that edge.
- **Tick timing:** the first tick after reset release occurs on cycle 2^P−1. `sw_out` changes only on entry, retrigger, or tick edges.

## Configuration
- **`SW_BOUNCE_LFSR_EN` defined:** the pattern bit is bit 0 of a 16-bit Fibonacci LFSR.
  - Polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
  - The LFSR advances on every tick, in any state, so the chatter is pseudo-random.
- **`SW_BOUNCE_LFSR_EN` undefined:** the pattern bit is `~sw_out`, giving a deterministic toggle each tick. No LFSR logic is instantiated.

## Test plan
All scenarios use P=2 and BOUNCE_TICKS=4, with the macro undefined unless stated.
- **Reset:** assert `reset` with `level_in`=0 → `sw_out`=0, `busy`=0, `done`=0 throughout; `busy` stays 0 for 100 cycles after release.
- **Rising request:** `level_in` 0→1 → 3 edges later `sw_out`=1 and `busy`=1.
  - Subsequent ticks give `sw_out` 0, 1, 0, then 1 on the fourth tick with a single `done` pulse and `busy`=0.
  - The total window is ≤16 cycles after entry.
- **Falling request:** `level_in` 1→0 from STABLE → mirrored pattern 0, 1, 0, 1, then 0 with `done`.
- **Retrigger:** toggle `level_in` back to 0 after 2 ticks of bouncing.
  - `sw_out`=0 and `b` restarts; no `done` occurs until 4 further ticks have elapsed.
  - The final value is 0 with exactly one `done` pulse.
- **Reset mid-operation:** pulse `reset` during BOUNCE with `level_in`=1 → `sw_out`=0 and `busy`=0 immediately. After release, the block re-enters BOUNCE 3 edges later.
- **LFSR mode:** define `SW_BOUNCE_LFSR_EN` and compare the `sw_out` chatter with a golden LFSR model seeded 16'hACE1 → bit-exact match. The settled value equals `level_in`, with one `done` pulse.
